grain_keystream_cipher: RTL and testbench
=========================================

# grain_keystream_cipher

- Downstream controller and consumer for the Grain keystream generator.
- Sequences the generator: one seed-load pulse, optional warm-up bits discarded, then keystream bits on demand.
- Packs keystream bits into bytes and XORs each byte with a plaintext byte taken on a valid/ready handshake.
- Emits ciphertext bytes on a second valid/ready handshake; drives the generator's `Par_load`/`shift_en` and consumes its `main_output`.

## Interface

- `WARMUP_CYCLES`, 160: keystream bits discarded after each seed load (must be ≥1).
- `Clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `start` in 1: request (re)keying; generator seeds must be stable on its `SEED_l`/`SEED_n` inputs this cycle.
- `par_load` out 1: to generator `Par_load`.
- `shift_en` out 1: to generator `shift_en`.
- `ks_bit` in 1: from generator `main_output` (combinational from generator state).
- `pt_data` in 8: plaintext byte.
- `pt_valid` in 1: plaintext byte present.
- `pt_ready` out 1: block accepts plaintext this cycle.
- `ct_data` out 8: ciphertext byte.
- `ct_valid` out 1: ciphertext present.
- `ct_ready` in 1: sink accepts ciphertext.
- `busy` out 1: high in LOAD/WARMUP.
- `byte_cnt` out 16: ciphertext bytes delivered since last load.

## Operation

- Reset state: IDLE. All outputs 0, including `ct_data`, `byte_cnt` and internal key byte.
- FSM states: IDLE, LOAD, WARMUP, COLLECT, WAIT_PT, OUT.
- IDLE: on `start` go to LOAD. No other input is honoured.
- LOAD:
  - `par_load`=1 for exactly one cycle; clear `byte_cnt`, bit counter and warm-up counter.
  - Next state: WARMUP (macro defined) or COLLECT.
- WARMUP:
  - `shift_en`=1 every cycle; `ks_bit` is ignored.
  - After `WARMUP_CYCLES` cycles go to COLLECT.
- COLLECT:
  - `shift_en`=1 every cycle.
  - Capture `ks_bit` in the same cycle the generator shifts: `ks_sr <= {ks_sr[6:0], ks_bit}`. The first bit collected ends as bit 7.
  - After 8 cycles go to WAIT_PT.
- WAIT_PT:
  - `pt_ready`=1, `shift_en`=0.
  - On `pt_valid`: `ct_data <= pt_data ^ ks_sr`, go to OUT.
  - `start` in WAIT_PT goes to LOAD (rekey). Simultaneous `start` and `pt_valid`: `start` wins, no plaintext is consumed.
- OUT:
  - `ct_valid`=1; `ct_data` is held stable.
  - On `ct_ready`: increment `byte_cnt` (wraps 0xFFFF→0x0000), go to COLLECT.
  - `start` is ignored in OUT.
- The generator never shifts outside WARMUP/COLLECT, so no keystream bit is lost or reused under backpressure.
- `par_load` and `shift_en` are never high together.

## Timing

- Outputs `par_load`, `shift_en`, `pt_ready`, `ct_valid`, `busy` are decoded from registered state only; none combinationally depends on inputs.
- With the macro: `start` at cycle 0 → LOAD cycle 1 → WARMUP cycles 2..1+W → COLLECT 8 cycles → `pt_ready` first high at cycle 10+W. W=160: cycle 170.
- Per-byte throughput with no stalls: 8 COLLECT + 1 WAIT_PT + 1 OUT = 10 cycles.
- Async reset mid-operation: immediately IDLE with outputs 0. The generator needs a new `start`.

## Configuration

- `GRAIN_WARMUP_EN` defined: WARMUP state present, `WARMUP_CYCLES` bits discarded after each load.
- `GRAIN_WARMUP_EN` undefined:
  - LOAD goes directly to COLLECT; `WARMUP_CYCLES` is unused.
  - `busy` is high only in LOAD.
  - First `pt_ready` is at cycle 10 after `start`.

## Test plan

- Stub `ks_bit`=1 constant, macro on, W=160: `start` at cycle 0 → `par_load` only at cycle 1, `shift_en` high 168 cycles. `pt_data`=0x3C → `ct_data`=0xC3, `byte_cnt`=1.
- Stub bit sequence 1,0,1,0,… from first COLLECT: key byte 0xAA. `pt_data`=0xFF → `ct_data`=0x55. Next byte with `pt_data`=0x00 → 0xAA.
- Backpressure: hold `ct_ready`=0 for 5 cycles in OUT → `ct_valid`=1 and `ct_data` stable, `shift_en`=0 throughout. Release → `byte_cnt` increments once.
- `start` and `pt_valid` together in WAIT_PT → LOAD taken, `pt_ready` drops, `byte_cnt`=0, no `ct_valid`.
- Reset low at warm-up cycle 50 → all outputs 0 that cycle. Release, then `start` → full 160-cycle warm-up restarts.
- Macro undefined: `start` at 0 → `shift_en` high cycles 2..9, `pt_ready` at cycle 10.

Source files
------------

// File: rtl/grain_keystream_cipher.sv
// grain_keystream_cipher: sequences a Grain generator and XORs its keystream bytes onto plaintext bytes.
// Define GRAIN_WARMUP_EN to discard WARMUP_CYCLES keystream bits after each seed load.
module grain_keystream_cipher #(
  parameter int WARMUP_CYCLES = 160
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  output logic        par_load,
  output logic        shift_en,
  input  logic        ks_bit,
  input  logic [7:0]  pt_data,
  input  logic        pt_valid,
  output logic        pt_ready,
  output logic [7:0]  ct_data,
  output logic        ct_valid,
  input  logic        ct_ready,
  output logic        busy,
  output logic [15:0] byte_cnt
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;
  logic [2:0]  state_q, state_d;
  logic [7:0]  ks_q, ks_d, ct_q, ct_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] cnt_q, cnt_d;
  logic        in_load, in_warm, in_collect, in_wait, in_out;
  assign in_load    = state_q == S_LOAD;
  assign in_collect = state_q == S_COLLECT;
  assign in_wait    = state_q == S_WAIT;
  assign in_out     = state_q == S_OUT;
`ifdef GRAIN_WARMUP_EN
  localparam logic [2:0] S_WARM = 3'd2;
  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  logic [WW-1:0] warm_q, warm_d;
  assign in_warm = state_q == S_WARM;
  assign warm_d  = in_load ? '0 : in_warm ? warm_q + 1'b1 : warm_q;
  always_ff @(posedge Clk or negedge reset)
    if (!reset) warm_q <= '0;
    else        warm_q <= warm_d;
`else
  assign in_warm = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    state_d = start ? S_LOAD : S_IDLE;
`ifdef GRAIN_WARMUP_EN
      S_LOAD:    state_d = S_WARM;
      S_WARM:    state_d = (warm_q == WW'(WARMUP_CYCLES - 1)) ? S_COLLECT : S_WARM;
`else
      S_LOAD:    state_d = S_COLLECT;
`endif
      S_COLLECT: state_d = (bit_q == 3'd7) ? S_WAIT : S_COLLECT;
      // A rekey request takes priority over a plaintext byte offered in the same cycle.
      S_WAIT:    state_d = start ? S_LOAD : pt_valid ? S_OUT : S_WAIT;
      S_OUT:     state_d = ct_ready ? S_COLLECT : S_OUT;
      default:   state_d = S_IDLE;
    endcase
  end
  assign ks_d  = in_collect ? {ks_q[6:0], ks_bit} : ks_q;
  assign bit_d = in_load ? 3'd0 : in_collect ? bit_q + 3'd1 : bit_q;
  assign ct_d  = (in_wait && pt_valid && !start) ? pt_data ^ ks_q : ct_q;
  assign cnt_d = in_load ? 16'd0 : (in_out && ct_ready) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      ks_q    <= '0;
      bit_q   <= '0;
      ct_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ks_q    <= ks_d;
      bit_q   <= bit_d;
      ct_q    <= ct_d;
      cnt_q   <= cnt_d;
    end
  assign par_load = in_load;
  assign shift_en = in_warm || in_collect;
  assign pt_ready = in_wait;
  assign ct_valid = in_out;
  assign busy     = in_load || in_warm;
  assign ct_data  = ct_q;
  assign byte_cnt = cnt_q;
endmodule

// File: tb/tb_grain_keystream_cipher.sv
// tb_grain_keystream_cipher: scoreboard bench driving the cipher with a rotating-pattern generator stub.
module tb_grain_keystream_cipher;
  localparam int W = 160;
`ifdef GRAIN_WARMUP_EN
  localparam int WU = W;
`else
  localparam int WU = 0;
`endif
  logic        Clk = 0, reset = 0, start = 0, ks_bit, pt_valid = 0, ct_ready = 1;
  logic        par_load, shift_en, pt_ready, ct_valid, busy;
  logic [7:0]  pt_data = 0, ct_data;
  logic [15:0] byte_cnt, seed = 16'hFFFF, pat = 16'h0000;
  logic [7:0]  exp_q[$];
  int          n_checks = 0, n_err = 0, overlap = 0;

  grain_keystream_cipher #(.WARMUP_CYCLES(W)) dut (
    .Clk(Clk), .reset(reset), .start(start), .par_load(par_load), .shift_en(shift_en),
    .ks_bit(ks_bit), .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready), .busy(busy), .byte_cnt(byte_cnt)
  );

  always #5 Clk = ~Clk;

  // Generator stub: 16-bit rotating pattern; 160 warm-up shifts bring it back to the seed.
  always @(posedge Clk)
    if (par_load) pat <= seed;
    else if (shift_en) pat <= {pat[14:0], pat[15]};
  assign ks_bit = pat[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (par_load && shift_en) overlap++;
    if (reset && ct_valid && ct_ready) begin
      if (exp_q.size() == 0) chk("unexpected_ct", {24'd0, ct_data}, 32'hFFFF_FFFF);
      else chk("ct_data", ct_data, exp_q.pop_front());
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_par_load"}, par_load, 0);
    chk({tag, "_shift_en"}, shift_en, 0);
    chk({tag, "_pt_ready"}, pt_ready, 0);
    chk({tag, "_ct_valid"}, ct_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ct_data"}, ct_data, 0);
    chk({tag, "_byte_cnt"}, byte_cnt, 0);
  endtask

  // Called at a negedge; start is high for cycle 0, samples from cycle 1 until pt_ready.
  task automatic rekey(input logic [15:0] s);
    int k, pl_n = 0, pl_at = 0, sh = 0, bz = 0;
    seed = s;
    start = 1;
    @(negedge Clk);
    start = 0;
    for (k = 1; k <= 400; k++) begin
      if (par_load) begin pl_n++; pl_at = k; end
      if (shift_en) sh++;
      if (busy) bz++;
      if (pt_ready) break;
      @(negedge Clk);
    end
    chk("ready_latency", k, 10 + WU);
    chk("par_load_count", pl_n, 1);
    chk("par_load_cycle", pl_at, 1);
    chk("shift_cycles", sh, 8 + WU);
    chk("busy_cycles", bz, 1 + WU);
    chk("byte_cnt_after_load", byte_cnt, 0);
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 50 && !pt_ready; k++) @(negedge Clk);
    if (!pt_ready) chk("pt_ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] pt, input logic [7:0] key);
    wait_ready();
    pt_valid = 1;
    pt_data = pt;
    exp_q.push_back(pt ^ key);
    @(negedge Clk);
    pt_valid = 0;
  endtask

  initial begin
    int cv;
    repeat (3) @(negedge Clk);
    check_zero("reset");
    reset = 1;
    @(negedge Clk);
    // Constant-one keystream
    rekey(16'hFFFF);
    send(8'h3C, 8'hFF);
    wait_ready();
    chk("byte_cnt_1", byte_cnt, 1);
    // Alternating keystream, rekey from WAIT_PT
    rekey(16'hAAAA);
    send(8'hFF, 8'hAA);
    send(8'h00, 8'hAA);
    wait_ready();
    chk("byte_cnt_2", byte_cnt, 2);
    // Backpressure in OUT must not consume keystream
    rekey(16'hA53C);
    ct_ready = 0;
    send(8'h00, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ct_valid", ct_valid, 1);
      chk("bp_ct_data", ct_data, 8'hA5);
      chk("bp_shift_en", shift_en, 0);
      @(negedge Clk);
    end
    chk("bp_byte_cnt_held", byte_cnt, 0);
    @(posedge Clk);
    #1 ct_ready = 1;
    @(negedge Clk);
    wait_ready();
    chk("bp_byte_cnt", byte_cnt, 1);
    send(8'hFF, 8'h3C);
    wait_ready();
    chk("bp_byte_cnt_2", byte_cnt, 2);
    // start and pt_valid together in WAIT_PT
    seed = 16'h5A5A;
    start = 1;
    pt_valid = 1;
    pt_data = 8'h77;
    @(negedge Clk);
    start = 0;
    pt_valid = 0;
    chk("rk_pt_ready", pt_ready, 0);
    chk("rk_par_load", par_load, 1);
    chk("rk_ct_valid", ct_valid, 0);
    @(negedge Clk);
    chk("rk_byte_cnt", byte_cnt, 0);
    cv = 0;
    for (int k = 0; k < 400 && !pt_ready; k++) begin
      if (ct_valid) cv++;
      @(negedge Clk);
    end
    chk("rk_no_ct_valid", cv, 0);
    chk("rk_ready_again", pt_ready, 1);
    send(8'h0F, 8'h5A);
    wait_ready();
    // Async reset mid warm-up (mid-collect without warm-up)
    seed = 16'hFFFF;
    start = 1;
    @(negedge Clk);
    start = 0;
    repeat ((WU > 0) ? 51 : 4) @(negedge Clk);
    chk("pre_reset_shift_en", shift_en, 1);
    #1 reset = 0;
    #1 check_zero("async_reset");
    @(negedge Clk);
    reset = 1;
    repeat (3) @(negedge Clk);
    chk("idle_after_reset", {par_load, shift_en, busy}, 0);
    rekey(16'hFFFF);
    send(8'h5A, 8'hFF);
    wait_ready();
    chk("byte_cnt_after_reset", byte_cnt, 1);
    chk("no_load_shift_overlap", overlap, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
